reg_arbiter: RTL

REG_ARBITER -- requirements
Module: reg_arbiter

---
 rtl/reg_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/reg_arbiter.sv
// reg_arbiter: two-requester round-robin arbiter in front of a small
// register bank of 2**AW words, each WIDTH bits wide.
//
// Each transaction takes three cycles:
//   IDLE  -> the winning request is captured
//   SERVE -> the bank is written, or read into the winner's rdata
//   ACK   -> a one-cycle ack pulse goes to the winner
// All outputs are registered.
//
// Ports
//   clk            : clock; all state updates on the rising edge
//   rst            : synchronous, active-high reset
//   req0/req1      : transaction request, per requester
//   rw0/rw1        : 1 = write, 0 = read
//   addr0/addr1    : target word address (AW bits)
//   wdata0/wdata1  : write data (WIDTH bits)
//   ack0/ack1      : one-cycle completion pulse
//   rdata0/rdata1  : last read result for each requester
//   gnt            : one-hot grant, bit0 = requester 0
//   busy           : high whenever the FSM is not in IDLE
module reg_arbiter #(
  parameter int WIDTH = 16,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             rw0,
  input  logic             rw1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic [1:0]       gnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;

  state_t state, state_nxt;

  logic             last;      // requester granted most recently
  logic             pick;      // arbitration result in IDLE
  logic             win_p0;    // captured winner
  logic             rw_p0;
  logic [AW-1:0]    addr_p0;
  logic [WIDTH-1:0] wdata_p0;
  logic [WIDTH-1:0] bank [2**AW];

  // On a tie the requester that did not win last time goes first.
  assign pick = (req0 && req1) ? ~last : req1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = SERVE;
      SERVE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture stage: winner's request is frozen here, so a req that drops
  // during SERVE or ACK does not affect the transaction in flight.
  always_ff @(posedge clk) begin
    if (state == IDLE && (req0 || req1)) begin
      win_p0   <= pick;
      rw_p0    <= pick ? rw1    : rw0;
      addr_p0  <= pick ? addr1  : addr0;
      wdata_p0 <= pick ? wdata1 : wdata0;
    end
  end

  // Access / ack stage: registered outputs, bank and grant pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= 2'b00;
      busy   <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      last   <= 1'b1;
      for (int i = 0; i < 2**AW; i++) bank[i] <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            last <= pick;
            gnt  <= pick ? 2'b10 : 2'b01;
          end
        end
        SERVE: begin
          if (rw_p0)       bank[addr_p0] <= wdata_p0;
          else if (win_p0) rdata1 <= bank[addr_p0];
          else             rdata0 <= bank[addr_p0];
          ack0 <= ~win_p0;
          ack1 <= win_p0;
        end
        ACK:     gnt <= 2'b00;
        default: gnt <= 2'b00;
      endcase
    end
  end

endmodule
